// File: rtl/fsm_mod_counter_if.sv
// Control and status bundle for fsm_mod_counter.
// The master drives enable/load/mode; the slave (the counter) returns count, Gray code, direction and tc.
interface fsm_mod_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count_out;
    logic [WIDTH-1:0] gray_out;
    logic             dir_out;
    logic             tc;

    modport master (
        output en, load, load_val, mode,
        input  count_out, gray_out, dir_out, tc
    );

    modport slave (
        input  en, load, load_val, mode,
        output count_out, gray_out, dir_out, tc
    );
endinterface

// File: rtl/fsm_mod_counter.sv
// Parametrised modulo counter with up/down/bounce/hold modes, clamped load, optional saturation,
// a registered terminal-count pulse and a combinational Gray-coded copy of the count.
module fsm_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 9,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    fsm_mod_counter_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO_C = '0;
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("fsm_mod_counter: WIDTH must be in 2..16");
        end
        if (MAX_COUNT < 1 || MAX_COUNT > ((1 << WIDTH) - 1)) begin : g_bad_max
            $error("fsm_mod_counter: MAX_COUNT must be in 1..2^WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] count_q, count_d;
    dir_t             dir_q, dir_d;
    logic             tc_q, tc_d;

    mode_t            mode_s;
    logic             at_max;
    logic             at_min;
    logic             in_range;
    logic             step_en;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;

    assign mode_s       = mode_t'(bus.mode);
    assign at_max       = (count_q == MAX_C);
    assign at_min       = (count_q == ZERO_C);
    assign in_range     = (count_q <= MAX_C);
    assign step_en      = bus.en && (mode_s != MODE_HOLD);
    assign load_clamped = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
    assign count_inc    = count_q + ONE_C;
    assign count_dec    = count_q - ONE_C;

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;

        if (bus.load) begin
            count_d = load_clamped;
        end else if (step_en) begin
            if (!in_range) begin
                // A corrupted count recovers to zero on the next enabled step.
                count_d = ZERO_C;
                if (mode_s == MODE_UP) begin
                    dir_d = DIR_UP;
                end else if (mode_s == MODE_DOWN) begin
                    dir_d = DIR_DOWN;
                end
            end else begin
                case (mode_s)
                    MODE_UP: begin
                        dir_d = DIR_UP;
                        if (!at_max) begin
                            count_d = count_inc;
                        end else begin
                            count_d = SATURATE ? MAX_C : ZERO_C;
                            tc_d    = 1'b1;
                        end
                    end
                    MODE_DOWN: begin
                        dir_d = DIR_DOWN;
                        if (!at_min) begin
                            count_d = count_dec;
                        end else begin
                            count_d = SATURATE ? ZERO_C : MAX_C;
                            tc_d    = 1'b1;
                        end
                    end
                    MODE_BOUNCE: begin
                        // Turning at an end reflects the count one step back inward.
                        if (dir_q == DIR_UP) begin
                            if (!at_max) begin
                                count_d = count_inc;
                            end else begin
                                count_d = MAX_C - ONE_C;
                                dir_d   = DIR_DOWN;
                                tc_d    = 1'b1;
                            end
                        end else begin
                            if (!at_min) begin
                                count_d = count_dec;
                            end else begin
                                count_d = ONE_C;
                                dir_d   = DIR_UP;
                                tc_d    = 1'b1;
                            end
                        end
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= ZERO_C;
            dir_q   <= DIR_UP;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count_out = count_q;
    assign bus.gray_out  = count_q ^ (count_q >> 1);
    assign bus.dir_out   = dir_q;
    assign bus.tc        = tc_q;

endmodule

// File: tb/tb_fsm_mod_counter.sv
// Bench for fsm_mod_counter: three instances (wrap, MAX_COUNT=3 wrap, saturate) share one stimulus stream
// and are checked every cycle against a spec-level model, plus hand-computed literal expectations.
module tb_fsm_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [1:0] mode;

    fsm_mod_counter_if #(.WIDTH(4)) ifa ();
    fsm_mod_counter_if #(.WIDTH(4)) ifb ();
    fsm_mod_counter_if #(.WIDTH(4)) ifc ();

    assign ifa.en = en;  assign ifa.load = load;  assign ifa.load_val = load_val;  assign ifa.mode = mode;
    assign ifb.en = en;  assign ifb.load = load;  assign ifb.load_val = load_val;  assign ifb.mode = mode;
    assign ifc.en = en;  assign ifc.load = load;  assign ifc.load_val = load_val;  assign ifc.mode = mode;

    fsm_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    fsm_mod_counter #(.WIDTH(4), .MAX_COUNT(3), .SATURATE(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    fsm_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

    logic [3:0] q_cnt  [3];
    logic [3:0] q_gray [3];
    logic       q_dir  [3];
    logic       q_tc   [3];

    assign q_cnt[0] = ifa.count_out;  assign q_gray[0] = ifa.gray_out;  assign q_dir[0] = ifa.dir_out;  assign q_tc[0] = ifa.tc;
    assign q_cnt[1] = ifb.count_out;  assign q_gray[1] = ifb.gray_out;  assign q_dir[1] = ifb.dir_out;  assign q_tc[1] = ifb.tc;
    assign q_cnt[2] = ifc.count_out;  assign q_gray[2] = ifc.gray_out;  assign q_dir[2] = ifc.dir_out;  assign q_tc[2] = ifc.tc;

    localparam int MAXV [3] = '{9, 3, 9};
    localparam int SATV [3] = '{0, 0, 1};

    // Spec-level model state
    int m_cnt [3];
    int m_dir [3];
    int m_tc  [3];
    bit model_valid = 1'b0;

    // Literal expectation for the current cycle
    bit    lit_valid = 1'b0;
    string lit_name  = "";
    int    lit_idx, lit_cnt, lit_dir, lit_tc, lit_gray;

    int checks = 0;
    int errors = 0;

    localparam int DN_CNT [4] = '{1, 0, 9, 8};
    localparam int DN_TC  [4] = '{0, 0, 1, 0};
    localparam int BN_CNT [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    localparam int BN_DIR [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    localparam int BN_TC  [8] = '{0, 0, 0, 1, 0, 0, 1, 0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: apply the behavioural rules on each rising edge using plain integers.
    initial begin
        int nxt;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (reset) begin
                    m_cnt[i] = 0;  m_dir[i] = 1;  m_tc[i] = 0;
                    model_valid = 1'b1;
                end else if (load) begin
                    m_cnt[i] = (int'(load_val) > MAXV[i]) ? MAXV[i] : int'(load_val);
                    m_tc[i]  = 0;
                end else if (!en || mode == 2'b11) begin
                    m_tc[i] = 0;
                end else begin
                    m_tc[i] = 0;
                    if (mode == 2'b00) begin
                        m_dir[i] = 1;
                        nxt = m_cnt[i] + 1;
                        if (nxt > MAXV[i]) begin nxt = (SATV[i] != 0) ? MAXV[i] : 0; m_tc[i] = 1; end
                    end else if (mode == 2'b01) begin
                        m_dir[i] = 0;
                        nxt = m_cnt[i] - 1;
                        if (nxt < 0) begin nxt = (SATV[i] != 0) ? 0 : MAXV[i]; m_tc[i] = 1; end
                    end else begin
                        nxt = (m_dir[i] != 0) ? m_cnt[i] + 1 : m_cnt[i] - 1;
                        if (nxt > MAXV[i] || nxt < 0) begin
                            m_dir[i] = (m_dir[i] != 0) ? 0 : 1;
                            nxt = (m_dir[i] != 0) ? 1 : MAXV[i] - 1;
                            m_tc[i] = 1;
                        end
                    end
                    m_cnt[i] = nxt;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare: all three DUTs against the model every cycle, plus the literal expectation if any.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("model_cnt[%0d]", i),  {28'b0, q_cnt[i]},  m_cnt[i]);
                    chk($sformatf("model_gray[%0d]", i), {28'b0, q_gray[i]}, m_cnt[i] ^ (m_cnt[i] >> 1));
                    chk($sformatf("model_dir[%0d]", i),  {31'b0, q_dir[i]},  m_dir[i]);
                    chk($sformatf("model_tc[%0d]", i),   {31'b0, q_tc[i]},   m_tc[i]);
                end
            end
            if (lit_valid) begin
                chk({lit_name, "_cnt"}, {28'b0, q_cnt[lit_idx]}, lit_cnt);
                chk({lit_name, "_dir"}, {31'b0, q_dir[lit_idx]}, lit_dir);
                chk({lit_name, "_tc"},  {31'b0, q_tc[lit_idx]},  lit_tc);
                if (lit_gray >= 0) chk({lit_name, "_gray"}, {28'b0, q_gray[lit_idx]}, lit_gray);
                $display("txn %s dut=%0d cnt=%0d dir=%0d tc=%0d", lit_name, lit_idx,
                         q_cnt[lit_idx], q_dir[lit_idx], q_tc[lit_idx]);
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic l, input logic [3:0] lv, input logic [1:0] m);
        @(negedge clk);
        #1;
        lit_valid = 1'b0;
        reset = r;  en = e;  load = l;  load_val = lv;  mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input int idx, input int c, input int d, input int t, input int g);
        lit_name = name;  lit_idx = idx;  lit_cnt = c;  lit_dir = d;  lit_tc = t;  lit_gray = g;
        lit_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;  en = 1'b0;  load = 1'b0;  load_val = 4'd0;  mode = 2'b00;

        step(1, 0, 0, 0, 0);                 expect_lit("reset", 0, 0, 1, 0, 0);

        // Up wrap on MAX_COUNT=9; gray at 9 is 4'b1101
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, 0);
            expect_lit($sformatf("up%0d", i), 0, (i + 1) % 10, 1, (i == 9) ? 1 : 0, (i == 8) ? 13 : -1);
        end

        // Down wrap from 2
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 1);
            expect_lit($sformatf("down%0d", i), 0, DN_CNT[i], 0, DN_TC[i], -1);
        end

        // Bounce on MAX_COUNT=3 from a fresh reset
        step(1, 0, 0, 0, 0);                 expect_lit("reset2", 1, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 2);
            expect_lit($sformatf("bounce%0d", i), 1, BN_CNT[i], BN_DIR[i], BN_TC[i], -1);
        end

        // Load priority over en, clamp, then wrap from the clamped value
        step(0, 1, 1, 14, 0);                expect_lit("load_clamp", 0, 9, 1, 0, -1);
        step(0, 1, 0, 0, 0);                 expect_lit("load_wrap", 0, 0, 1, 1, 0);
        step(0, 0, 1, 5, 0);                 expect_lit("load5", 0, 5, 1, 0, 7);

        // Saturate instance pinned at the top
        step(0, 0, 1, 8, 0);                 expect_lit("sat_load", 2, 8, 1, 0, -1);
        step(0, 1, 0, 0, 0);                 expect_lit("sat_up0", 2, 9, 1, 0, -1);
        step(0, 1, 0, 0, 0);                 expect_lit("sat_up1", 2, 9, 1, 1, -1);
        step(0, 1, 0, 0, 0);                 expect_lit("sat_up2", 2, 9, 1, 1, -1);
        step(0, 1, 0, 0, 1);                 expect_lit("sat_down", 2, 8, 0, 0, -1);
        step(0, 1, 0, 0, 3);                 expect_lit("sat_hold", 2, 8, 0, 0, -1);

        // Reset mid-bounce at count 2, dir down
        step(0, 0, 1, 4, 1);                 expect_lit("pre_load4", 0, 4, 0, 0, -1);
        step(0, 1, 0, 0, 1);                 expect_lit("pre_down3", 0, 3, 0, 0, -1);
        step(0, 1, 0, 0, 2);                 expect_lit("pre_bnc2", 0, 2, 0, 0, -1);
        // Reset and load raised with no edge yet: outputs must not move until the edge
        reset = 1'b1;  load = 1'b1;  load_val = 4'd7;  en = 1'b1;  mode = 2'b10;
        @(posedge clk);
        #1;
        expect_lit("rst_mid", 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);                 expect_lit("after_rst", 0, 0, 1, 0, 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
